// File: rtl/nvram_upload_server_if.sv
// hps_io ioctl upload channel plus NVRAM port-B signals seen by nvram_upload_server.
// slave = the upload server, master = hps_io / NVRAM / game side.
interface nvram_upload_server_if #(
    parameter int ADDR_W = 10
);
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic [24:0]       ioctl_addr;
    logic              ioctl_rd;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              ioctl_upload_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_dout;
    logic              ram_we_mon;
    logic              osd_status;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        input  ram_dout, ram_we_mon, osd_status,
        output ioctl_din, ioctl_wait, ioctl_upload_req, ram_addr, ram_rd
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        output ram_dout, ram_we_mon, osd_status,
        input  ioctl_din, ioctl_wait, ioctl_upload_req, ram_addr, ram_rd
    );
endinterface

// File: rtl/nvram_upload_server.sv
// Serves hps_io upload byte reads from NVRAM port B, holding ioctl_wait until the byte is valid.
// Define NVRAM_AUTOSAVE_EN to track game writes and request an upload when the OSD opens.
module nvram_upload_server #(
    parameter int ADDR_W       = 10,
    parameter int UPLOAD_INDEX = 4,
    parameter int RD_LATENCY   = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    nvram_upload_server_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] lat_cnt;
    logic       match;
    logic       strobe;
    logic       in_range;
    logic       lat_done;

    always_comb begin
        match    = bus.ioctl_upload && (bus.ioctl_index == 8'(UPLOAD_INDEX));
        strobe   = bus.ioctl_rd && match;
        in_range = (bus.ioctl_addr >> ADDR_W) == '0;
        // lat_cnt counts cycles since the strobe edge, so FETCH is already cycle 1.
        lat_done = (lat_cnt == 3'(RD_LATENCY));
    end

    // NOTE: wait is combinational so hps_io sees it in the very cycle of its strobe.
    assign bus.ioctl_wait = (strobe && (state == S_IDLE)) || (state != S_IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (strobe) begin
                    state_next = in_range ? S_FETCH : S_PRESENT;
                end
            end
            S_FETCH, S_WAIT: begin
                state_next = lat_done ? S_PRESENT : S_WAIT;
            end
            S_PRESENT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.ioctl_din <= 8'h00;
            bus.ram_addr  <= '0;
            bus.ram_rd    <= 1'b0;
            lat_cnt       <= '0;
        end else begin
            bus.ram_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (strobe) begin
                        if (in_range) begin
                            bus.ram_addr <= bus.ioctl_addr[ADDR_W-1:0];
                            bus.ram_rd   <= 1'b1;
                            lat_cnt      <= 3'd1;
                        end else begin
                            bus.ioctl_din <= 8'hFF;
                        end
                    end
                end
                S_FETCH, S_WAIT: begin
                    if (lat_done) begin
                        bus.ioctl_din <= bus.ram_dout;
                        lat_cnt       <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NVRAM_AUTOSAVE_EN
    logic dirty;
    logic osd_q;
    logic match_q;
    logic upload_req;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dirty      <= 1'b0;
            osd_q      <= 1'b0;
            match_q    <= 1'b0;
            upload_req <= 1'b0;
        end else begin
            osd_q      <= bus.osd_status;
            match_q    <= match;
            upload_req <= bus.osd_status && !osd_q && dirty && !bus.ioctl_upload;
            // A game write coinciding with the end of our upload keeps the image dirty.
            if (bus.ram_we_mon) begin
                dirty <= 1'b1;
            end else if (match_q && !bus.ioctl_upload) begin
                dirty <= 1'b0;
            end
        end
    end

    assign bus.ioctl_upload_req = upload_req;
`else
    logic unused_autosave;
    assign unused_autosave = &{1'b0, bus.ram_we_mon, bus.osd_status};
    assign bus.ioctl_upload_req = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_upload_server.sv
// Directed bench for nvram_upload_server with a 2-cycle NVRAM model preloaded with a byte ramp.
// Build with or without NVRAM_AUTOSAVE_EN; upload_req expectations follow the macro.
module tb_nvram_upload_server;
    localparam int ADDR_W = 10;
    localparam int LAT    = 2;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    int   rd_count  = 0;
    int   req_count = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] ram_q;
    logic [7:0] image [0:(1<<ADDR_W)-1];

    nvram_upload_server_if #(.ADDR_W(ADDR_W)) bus ();

    nvram_upload_server #(
        .ADDR_W      (ADDR_W),
        .UPLOAD_INDEX(4),
        .RD_LATENCY  (LAT)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // One register stage after the DUT's address register gives LAT=2 from the strobe edge.
    always @(posedge clk_sys) ram_q <= mem[bus.ram_addr];
    assign bus.ram_dout = ram_q;

    always @(posedge clk_sys) begin
        if (bus.ram_rd) rd_count <= rd_count + 1;
        if (bus.ioctl_upload_req) req_count <= req_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe once, then count cycles with wait high (strobe cycle included); bounded at 17.
    task automatic do_read(input logic [24:0] a, output int wcyc, output logic [7:0] d);
        @(negedge clk_sys);
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        #1;
        wcyc = bus.ioctl_wait ? 1 : 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys);
            bus.ioctl_rd = 1'b0;
            #1;
            if (!bus.ioctl_wait) break;
            wcyc++;
        end
        d = bus.ioctl_din;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    initial begin
        int         wcyc;
        int         rd_base;
        int         req_base;
        int         errs;
        logic [7:0] d;
        int         exp_req;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i[7:0];
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd0;
        bus.ioctl_addr   = '0;
        bus.ioctl_rd     = 1'b0;
        bus.ram_we_mon   = 1'b0;
        bus.osd_status   = 1'b0;

        // Reset state
        @(negedge clk_sys);
        #1;
        check("rst_din", bus.ioctl_din, 8'h00);
        check("rst_wait", bus.ioctl_wait, 1'b0);
        check("rst_ram_rd", bus.ram_rd, 1'b0);
        check("rst_ram_addr", bus.ram_addr, 10'h000);
        check("rst_req", bus.ioctl_upload_req, 1'b0);
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(2);

        // 1: basic read
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = 8'd4;
        rd_base = rd_count;
        do_read(25'h012, wcyc, d);
        check("t1_wait_cycles", wcyc, 4);
        check("t1_din", d, 8'h12);
        check("t1_ram_rd_count", rd_count - rd_base, 1);
        do_read(25'h1A5, wcyc, d);
        check("t1b_din", d, 8'hA5);
        do_read(25'h3FE, wcyc, d);
        check("t1c_din_top", d, 8'hFE);
        check("t1c_wait_cycles", wcyc, 4);
        do_read(25'h000, wcyc, d);
        check("t1d_din_zero", d, 8'h00);

        // 2: out of range
        rd_base = rd_count;
        do_read(25'h400, wcyc, d);
        check("t2_wait_cycles", wcyc, 2);
        check("t2_din", d, 8'hFF);
        check("t2_ram_rd_count", rd_count - rd_base, 0);
        idle_cycles(3);
        #1;
        check("t2_din_hold", bus.ioctl_din, 8'hFF);
        do_read(25'h1FFFFFF, wcyc, d);
        check("t2b_wait_cycles", wcyc, 2);

        // 3: non-matching index / upload low ignored
        do_read(25'h033, wcyc, d);
        bus.ioctl_index = 8'd3;
        rd_base = rd_count;
        do_read(25'h044, wcyc, d);
        check("t3_wait", wcyc, 0);
        check("t3_din_unchanged", d, 8'h33);
        bus.ioctl_index  = 8'd4;
        bus.ioctl_upload = 1'b0;
        do_read(25'h055, wcyc, d);
        check("t3b_wait", wcyc, 0);
        check("t3_ram_rd_count", rd_count - rd_base, 0);
        bus.ioctl_upload = 1'b1;

        // Strobe during WAIT is ignored
        rd_base = rd_count;
        @(negedge clk_sys);
        bus.ioctl_addr = 25'h020;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_rd   = 1'b0;
        @(negedge clk_sys);
        bus.ioctl_addr = 25'h030;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_rd   = 1'b0;
        #1;
        check("busy_wait_pres", bus.ioctl_wait, 1'b1);
        @(negedge clk_sys);
        #1;
        check("busy_wait_low", bus.ioctl_wait, 1'b0);
        check("busy_din_first", bus.ioctl_din, 8'h20);
        idle_cycles(4);
        check("busy_ram_rd_count", rd_count - rd_base, 1);

        // 4: reset while in WAIT
        @(negedge clk_sys);
        bus.ioctl_addr = 25'h077;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_rd   = 1'b0;
        @(negedge clk_sys);
        #1;
        check("t4_wait_before", bus.ioctl_wait, 1'b1);
        reset = 1'b1;
        #1;
        check("t4_wait_rst", bus.ioctl_wait, 1'b0);
        check("t4_ram_rd_rst", bus.ram_rd, 1'b0);
        check("t4_din_rst", bus.ioctl_din, 8'h00);
        check("t4_ram_addr_rst", bus.ram_addr, 10'h000);
        idle_cycles(2);
        reset = 1'b0;
        do_read(25'h005, wcyc, d);
        check("t4_after_din", d, 8'h05);
        check("t4_after_wait", wcyc, 4);

        // 5: autosave request
`ifdef NVRAM_AUTOSAVE_EN
        exp_req = 1;
`else
        exp_req = 0;
`endif
        bus.ioctl_upload = 1'b0;
        req_base = req_count;
        @(negedge clk_sys);
        bus.ram_we_mon = 1'b1;
        @(negedge clk_sys);
        bus.ram_we_mon = 1'b0;
        idle_cycles(2);
        bus.osd_status = 1'b1;
        idle_cycles(4);
        check("t5_req_on_open", req_count - req_base, exp_req);
        bus.osd_status   = 1'b0;
        bus.ioctl_upload = 1'b1;
        idle_cycles(3);
        bus.ioctl_upload = 1'b0;
        idle_cycles(3);
        bus.osd_status = 1'b1;
        idle_cycles(4);
        check("t5_no_req_after_clear", req_count - req_base, exp_req);
        bus.osd_status   = 1'b0;
        bus.ioctl_upload = 1'b1;
        idle_cycles(3);
        bus.ioctl_upload = 1'b0;
        bus.ram_we_mon   = 1'b1;
        @(negedge clk_sys);
        bus.ram_we_mon = 1'b0;
        idle_cycles(2);
        bus.osd_status = 1'b1;
        idle_cycles(4);
        check("t5_we_wins_clear", req_count - req_base, 2 * exp_req);
        bus.osd_status = 1'b0;

        // 6: full image upload
        bus.ioctl_upload = 1'b1;
        rd_base = rd_count;
        errs = 0;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            do_read(25'(a), wcyc, d);
            image[a] = d;
            if (wcyc != LAT + 2) errs++;
        end
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            if (image[a] !== a[7:0]) errs++;
        end
        check("t6_image_errors", errs, 0);
        check("t6_ram_rd_count", rd_count - rd_base, 1 << ADDR_W);
        bus.ioctl_upload = 1'b0;
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
